// File: rtl/line_fill_responder.sv
// line_fill_responder: serves a 32-byte cache line request by fetching eight
// 32-bit words from backing memory and returning the assembled line.
//
// Ports
//   clk         sole clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   addr_i      line request byte address, may be unaligned
//   rd_i        line read request level, sampled only in IDLE
//   data_o      assembled line, word k in bits [32k+31:32k]
//   ack_o       one-cycle pulse, data_o valid in that cycle
//   mem_addr_o  word byte address to memory, bits [1:0] always 0
//   mem_rd_o    word read request level
//   mem_data_i  word read data
//   mem_ack_i   beat complete, honoured only while mem_rd_o is high
//
// Configuration
//   LINE_FILL_CRITICAL_WORD_FIRST_EN  defined: fetch starts at word addr_i[4:2]
//                                     and wraps 7->0; undefined: order 0..7.
module line_fill_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_i,
    input  logic         rd_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_rd_o,
    input  logic [31:0]  mem_data_i,
    input  logic         mem_ack_i
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BASE_W = ADDR_W - OFS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [BASE_W-1:0]   r_base, w_base_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [IDX_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [LINE_W-1:0]   r_data, w_data_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_mem_rd, w_mem_rd_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;

    logic [IDX_W-1:0]    w_start_idx;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_beat;

    // First word of the fill: critical word or always word 0.
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^addr_i[1:0];
    assign w_start_idx   = addr_i[4:2];
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^addr_i[OFS_W-1:0];
    assign w_start_idx   = IDX_W'(0);
`endif

    // A beat needs an outstanding request; stray acks are dropped here.
    assign w_beat    = r_mem_rd & mem_ack_i;
    assign w_idx_inc = r_idx + IDX_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_idx      <= '0;
            r_beat_cnt <= '0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_idx      <= w_idx_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_data     <= w_data_nxt;
            r_ack      <= w_ack_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_idx_nxt      = r_idx;
        w_beat_cnt_nxt = r_beat_cnt;
        w_data_nxt     = r_data;
        w_ack_nxt      = 1'b0;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_addr_nxt = r_mem_addr;

        case (r_state)
            IDLE: begin
                if (rd_i) begin
                    w_state_nxt    = FILL;
                    w_base_nxt     = addr_i[ADDR_W-1:OFS_W];
                    w_idx_nxt      = w_start_idx;
                    w_beat_cnt_nxt = '0;
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_addr_nxt = {addr_i[ADDR_W-1:OFS_W], w_start_idx, 2'b00};
                end
            end
            FILL: begin
                if (w_beat) begin
                    w_data_nxt[{r_idx, 5'b00000} +: WORD_W] = mem_data_i;
                    w_idx_nxt      = w_idx_inc;
                    w_beat_cnt_nxt = r_beat_cnt + IDX_W'(1);
                    w_mem_addr_nxt = {r_base, w_idx_inc, 2'b00};
                    // Eighth beat closes the fill.
                    if (r_beat_cnt == IDX_W'(7)) begin
                        w_state_nxt  = ACK;
                        w_mem_rd_nxt = 1'b0;
                        w_ack_nxt    = 1'b1;
                    end
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_mem_rd_nxt = 1'b0;
            end
        endcase
    end

    assign data_o     = r_data;
    assign ack_o      = r_ack;
    assign mem_addr_o = r_mem_addr;
    assign mem_rd_o   = r_mem_rd;

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: expected word addresses and lines
// are queued when a request is issued and compared as beats and acks occur.
module tb_line_fill_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_i;
    logic         rd_i;
    logic [255:0] data_o;
    logic         ack_o;
    logic [31:0]  mem_addr_o;
    logic         mem_rd_o;
    logic [31:0]  mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  salt;

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_addr_q[$];
    logic [255:0] exp_line_q[$];
    logic [255:0] last_line;

    line_fill_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .rd_i       (rd_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk = ~clk;

    // Backing memory returns its address scrambled by a per-test salt.
    assign mem_data_i = mem_addr_o ^ salt;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a, input logic [31:0] s);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++)
            l[k*32 +: 32] = ({a[31:5], 5'b00000} + 32'(4 * k)) ^ s;
        return l;
    endfunction

    // Queue the expected fetch order and final line, then raise the request.
    task automatic start_req(input logic [31:0] a);
        logic [2:0] st;
        logic [2:0] ix;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
        st = a[4:2];
`else
        st = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            ix = st + 3'(k);
            exp_addr_q.push_back({a[31:5], ix, 2'b00});
        end
        exp_line_q.push_back(line_of(a, salt));
        addr_i = a;
        rd_i   = 1'b1;
    endtask

    // Clock a fill to its ack (or stop after stop_after beats), scoring each beat.
    task automatic run_fill(input string tag, input int ack_period, input int drop_after,
                            input int stop_after, input bit hold, input int exp_lat,
                            input logic [31:0] next_addr);
        int          cyc;
        int          beats;
        bit          done;
        logic        rd_pre;
        logic        beat_pre;
        logic [31:0] addr_pre;
        cyc   = 0;
        beats = 0;
        done  = 1'b0;
        while (!done && cyc < 200) begin
            mem_ack_i = ((cyc % ack_period) == ack_period - 1);
            rd_pre    = mem_rd_o;
            beat_pre  = mem_rd_o & mem_ack_i;
            addr_pre  = mem_addr_o;
            @(posedge clk);
            #1;
            cyc++;
            if (beat_pre) begin
                beats++;
                if (exp_addr_q.size() > 0)
                    check({tag, "_addr"}, 256'(addr_pre), 256'(exp_addr_q.pop_front()));
                else
                    check({tag, "_beats"}, 256'(beats), 256'(8));
            end else if (rd_pre && mem_rd_o) begin
                check({tag, "_stall_hold"}, 256'(mem_addr_o), 256'(addr_pre));
            end
            if (beats == drop_after)
                rd_i = 1'b0;
            if (stop_after > 0 && beats == stop_after) begin
                mem_ack_i = 1'b0;
                return;
            end
            if (ack_o) begin
                done = 1'b1;
                if (exp_line_q.size() > 0) begin
                    last_line = exp_line_q.pop_front();
                    check({tag, "_line"}, data_o, last_line);
                end else begin
                    check({tag, "_unexpected_ack"}, 256'(ack_o), 256'(0));
                end
                check({tag, "_beat_count"}, 256'(beats), 256'(8));
                if (exp_lat > 0)
                    check({tag, "_latency"}, 256'(cyc + 1), 256'(exp_lat));
                if (hold)
                    start_req(next_addr);
                else
                    rd_i = 1'b0;
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 256'(done), 256'(1));
            return;
        end
        mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ack_single"}, 256'(ack_o), 256'(0));
        check({tag, "_rd_low_after"}, 256'(mem_rd_o), 256'(0));
    endtask

    initial begin
        rst       = 1'b1;
        rd_i      = 1'b0;
        addr_i    = '0;
        mem_ack_i = 1'b0;
        salt      = '0;
        last_line = '0;

        @(posedge clk);
        #1;
        check("rst_data", data_o, 256'(0));
        check("rst_ack", 256'(ack_o), 256'(0));
        check("rst_rd", 256'(mem_rd_o), 256'(0));
        check("rst_addr", 256'(mem_addr_o), 256'(0));

        // Request raised with reset release; the first rising edge captures it.
        @(negedge clk);
        rst = 1'b0;
        start_req(32'h0000_1000);
        run_fill("aligned", 1, -1, 0, 1'b0, 10, 32'h0);

        start_req(32'h0000_1018);
        run_fill("wrap", 1, -1, 0, 1'b0, 10, 32'h0);

        salt = 32'hA5A5_0000;
        start_req(32'h0000_4004);
        run_fill("stall", 3, -1, 0, 1'b0, 0, 32'h0);

        // Stray memory acks with no fill outstanding.
        rd_i      = 1'b0;
        mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("spur_rd", 256'(mem_rd_o), 256'(0));
            check("spur_ack", 256'(ack_o), 256'(0));
        end
        check("spur_data_hold", data_o, last_line);

        salt = 32'h1111_1111;
        start_req(32'h0000_3008);
        run_fill("drop", 1, 2, 0, 1'b0, 10, 32'h0);

        salt = 32'h0000_005A;
        start_req(32'h0000_1000);
        run_fill("b2b_first", 1, -1, 0, 1'b1, 10, 32'h0000_2000);
        run_fill("b2b_second", 1, -1, 0, 1'b0, 10, 32'h0);

        // Reset in the middle of a fill.
        salt = 32'hDEAD_0000;
        start_req(32'h0000_5000);
        run_fill("rst_mid", 1, -1, 3, 1'b0, 0, 32'h0);
        #2;
        rst  = 1'b1;
        rd_i = 1'b0;
        #1;
        check("rst_mid_rd", 256'(mem_rd_o), 256'(0));
        check("rst_mid_data", data_o, 256'(0));
        check("rst_mid_ack", 256'(ack_o), 256'(0));
        exp_addr_q.delete();
        exp_line_q.delete();
        mem_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_ack", 256'(ack_o), 256'(0));
            check("post_rst_rd", 256'(mem_rd_o), 256'(0));
        end

        salt = 32'h0F0F_0F0F;
        start_req(32'h0000_600C);
        run_fill("after_rst", 1, -1, 0, 1'b0, 10, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: addr_i  input  32  line request byte address from cache initiator; may be unaligned.
REQ-004 SHALL have: rd_i  input  1  line read request, level, held by initiator until ack_o.
REQ-005 SHALL have: data_o  output  256  assembled line; word k in bits [32k+31:32k].
REQ-006 SHALL have: ack_o  output  1  one-cycle pulse, data_o valid that cycle.
REQ-007 SHALL have: mem_addr_o  output  32  word byte address to backing memory, bits [1:0] = 0.
REQ-008 SHALL have: mem_rd_o  output  1  word read request, level.
REQ-009 SHALL have: mem_data_i  input  32  word read data.
REQ-010 SHALL have: mem_ack_i  input  1  beat complete; valid only while mem_rd_o=1.

Function
REQ-011 SHALL implement FSM states IDLE, FILL, ACK.
REQ-012 IDLE: when rd_i=1, SHALL latch base = {addr_i[31:5], 5'b0} and start word index, go to FILL next cycle; addr_i/rd_i ignored outside IDLE.
REQ-013 FILL: mem_rd_o=1, mem_addr_o = base + 4*idx, both registered and stable until mem_ack_i.
REQ-014 A beat SHALL complete on any cycle with mem_rd_o=1 and mem_ack_i=1: mem_data_i stored into data_o word idx, idx advances, beat counter (3-bit) increments.
REQ-015 Back-to-back beats SHALL be supported: mem_ack_i high on consecutive cycles completes one beat per cycle, mem_addr_o advancing each cycle.
REQ-016 idx SHALL advance modulo 8 (3-bit wrap); address never leaves the 32-byte line.
REQ-017 After the 8th beat, mem_rd_o SHALL drop the next cycle and FSM enter ACK.
REQ-018 ACK: ack_o=1 for exactly one cycle, then IDLE; minimum request-to-ack latency = 10 cycles (1 capture + 8 single-cycle beats + 1 ack).
REQ-019 mem_ack_i while mem_rd_o=0 SHALL be ignored.
REQ-020 rd_i dropping during FILL SHALL NOT abort the fill; ack_o still pulses.
REQ-021 rd_i still high in the cycle after ACK SHALL start a new fill (initiator responsible for dropping on ack).
REQ-022 data_o SHALL hold its last value outside fills; words not yet written in a fill retain prior values until ACK.
REQ-023 mem_wait counting SHALL be unbounded; no timeout.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force IDLE, idx=0, beat count=0, data_o=0, ack_o=0, mem_rd_o=0, mem_addr_o=0.
REQ-025 Reset mid-FILL SHALL abandon the fill with no ack_o; a mem_ack_i arriving after reset is ignored per REQ-019.
REQ-026 First request SHALL be accepted on the first clock edge with rst=0.

Configuration
REQ-027 Macro LINE_FILL_CRITICAL_WORD_FIRST_EN SHALL select fetch order.
REQ-028 Defined: start idx = addr_i[4:2], wrap 7->0, so requested word is fetched first.
REQ-029 Undefined: start idx = 0 always, addr_i[4:0] ignored; order 0..7.
REQ-030 Both modes: data_o word placement by idx, final line identical; latency identical.

Verification
REQ-031 Aligned fill: addr_i=0x0000_1000, rd_i=1, mem_ack_i always 1, mem_data_i=mem_addr_o -> mem_addr_o 0x1000..0x101C, ack_o at cycle 10, data_o word k = 0x1000+4k.
REQ-032 Wrap (macro defined): addr_i=0x0000_1018 -> mem_addr_o order 0x1018,0x101C,0x1000..0x1014; same data_o as REQ-031. Macro undefined: order 0x1000..0x101C.
REQ-033 Stalls: mem_ack_i asserted only every 3rd cycle -> mem_addr_o stable during stalls, ack_o single pulse after 8th beat, correct data_o.
REQ-034 Reset mid-fill: assert rst after beat 3 -> mem_rd_o=0, data_o=0 same cycle; no ack_o; next request fills correctly.
REQ-035 Spurious/abort: mem_ack_i=1 in IDLE -> no state change; rd_i dropped after beat 2 -> fill completes, ack_o pulses once.
REQ-036 Back-to-back requests: rd_i held across ACK with new addr_i=0x2000 -> second fill starts cycle after ack_o, base 0x2000.
